// File: rtl/dds_ram_sequencer.sv
// DDS waveform RAM sequencer: arbitrates the single RAM port between host
// writes and the phase-accumulator reader, and runs the IDLE / CLEAR / RUN modes.
// DEPTH must equal 2**ADDR_WIDTH and PHASE_WIDTH must be >= ADDR_WIDTH.
module dds_ram_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 4096,
  parameter int PHASE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear_start,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic                   ftw_wr,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   ram_we,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  output logic [DATA_WIDTH-1:0]  sample,
  output logic                   sample_valid,
  output logic                   clear_done,
  output logic                   running
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [PHASE_WIDTH-1:0]  phase;
  logic [PHASE_WIDTH-1:0]  ftw_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    wr_last;
  logic                    grant;

  // After a granted write in RUN the host is held off one cycle so the
  // reader always gets at least every other cycle of the port.
  assign wr_ready = !rst && ((state == IDLE) || ((state == RUN) && !wr_last));
  assign grant    = wr_valid && wr_ready;
  assign running  = (state == RUN);

  // RAM port mux: host write wins, then clear fill, then the DDS read address.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant) begin
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end else if (!rst && state == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
    end else if (state == RUN) begin
      ram_addr  = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
    end
  end

  // Mode sequencing, phase accumulation and registered sample capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      ftw_reg      <= '0;
      clr_cnt      <= '0;
      wr_last      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      // Accumulation below still sees the old ftw_reg this edge.
      if (ftw_wr) ftw_reg <= ftw;
      wr_last      <= grant;
      sample_valid <= 1'b0;
      clear_done   <= 1'b0;
      case (state)
        IDLE: begin
          phase <= '0;
          if (clear_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (enable) begin
            state <= RUN;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state      <= IDLE;
            clear_done <= 1'b1;
          end
        end
        RUN: begin
          // A stolen cycle drops one sample but the phase keeps advancing,
          // so the output frequency is unaffected.
          phase <= phase + ftw_reg;
          if (!grant) begin
            sample       <= ram_rdata;
            sample_valid <= 1'b1;
          end
          if (!enable) begin
            state <= IDLE;
            phase <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dds_ram_sequencer.md
Name: dds_ram_sequencer

Overview:
- Owns the single port of the DDS waveform block RAM (async read, sync write) and shares it between two users:
  - a host loader that writes waveform samples;
  - the DDS phase accumulator that reads one sample per clock.
- Sequences three operating modes: idle/load, RAM clear, and run.
- Sits between the control/register interface and the waveform RAM. Its registered sample output feeds the DAC path.

Parameters:
- ADDR_WIDTH, 12: RAM address width.
- DATA_WIDTH, 8: sample width.
- DEPTH, 4096: RAM depth. Must equal 2**ADDR_WIDTH.
- PHASE_WIDTH, 32: phase accumulator width. Must be >= ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level; run the DDS.
- clear_start  in  1  pulse; zero-fill the RAM.
- ftw  in  PHASE_WIDTH  frequency tuning word.
- ftw_wr  in  1  latch ftw.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle.
- wr_addr  in  ADDR_WIDTH  host write address.
- wr_data  in  DATA_WIDTH  host write data.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data_in.
- ram_rdata  in  DATA_WIDTH  from RAM data_out (combinational read).
- sample  out  DATA_WIDTH  registered waveform sample.
- sample_valid  out  1  sample updated this cycle.
- clear_done  out  1  one-cycle pulse at end of clear.
- running  out  1  state == RUN.

Behaviour:
- **Reset** (rst=1 at an edge): state=IDLE, phase=0, ftw_reg=0, clr_cnt=0, wr_last=0, sample=0, sample_valid=0, clear_done=0. While rst is high, wr_ready=0 and ram_we=0 combinationally. Reset is honoured from any state, including mid-CLEAR or mid-RUN.
- **ftw_wr** in any state: ftw_reg<=ftw. The new value is used from the next accumulation.
- **wr_ready** is a function of state and wr_last only, never of wr_valid:
  - 1 in IDLE;
  - in RUN, equal to !wr_last;
  - 0 in CLEAR.
- **Grant** = wr_valid && wr_ready. On grant: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
- **IDLE**:
  - phase held at 0; no reads; sample holds; sample_valid=0.
  - Priority: clear_start -> CLEAR (clr_cnt=0); else enable -> RUN (phase=0).
  - A grant in the same cycle as a transition still completes.
- **CLEAR**:
  - each cycle: ram_we=1, ram_addr=clr_cnt, ram_wdata=0, clr_cnt++.
  - After writing address DEPTH-1: next state IDLE, clear_done=1 for exactly that next cycle.
  - Takes exactly DEPTH cycles. enable and clear_start are ignored until back in IDLE.
- **RUN**:
  - Every cycle: phase<=phase+ftw_reg, modulo 2**PHASE_WIDTH (natural wrap, no saturation).
  - Read cycle (no grant): ram_addr=phase[PHASE_WIDTH-1 -: ADDR_WIDTH], ram_we=0; next edge sample<=ram_rdata, sample_valid<=1. Latency: phase value in cycle n -> sample valid in cycle n+1.
  - Grant cycle: the write steals the port; next cycle sample holds and sample_valid=0. Phase still advances, so output frequency is preserved and one sample is dropped.
  - wr_last<=grant. After a granted write, wr_ready=0 for one cycle, so the reader gets at least every other cycle.
  - enable=0 -> IDLE (phase reset to 0). clear_start is ignored.
- **Transition timing**: enable sampled high in IDLE -> first RUN cycle reads address 0 -> first sample_valid 2 cycles after the enable edge.
- **Simultaneous events**: write and mode change in the same cycle -> the write is performed, then the transition. ftw_wr in the same cycle as an accumulation -> the old ftw_reg is used for that accumulation.

Test Plan:
1. Reset, IDLE; write addr 0..3 with data 0x10,0x20,0x30,0x40, wr_valid held 4 cycles -> wr_ready=1 on all 4; ram_we=1 on 4 cycles with matching addr/data; sample_valid=0 throughout.
2. ftw=0x0010_0000 with ftw_wr, then enable=1 -> running=1 next cycle; ram_addr 0,1,2,3; sample 0x10,0x20,0x30,0x40 with sample_valid=1, the first appearing 2 cycles after the enable edge.
3. RUN with wr_valid held 4 cycles, wr_addr=5, wr_data=0xAA -> grants on alternate cycles (wr_ready 1,0,1,0); sample_valid=0 in the cycle after each grant; read addresses skip accordingly, phase advancing 0x0010_0000 every cycle.
4. ftw=0x8000_0000, RUN -> ram_addr alternates 0, 2048; phase wraps to 0 with no glitch. ftw=0xFFFF_FFFF -> ram_addr sequence 0, 4095, 4095, ...
5. clear_start in IDLE while enable=1 -> exactly 4096 cycles of ram_we=1, wdata=0, addr 0..4095; clear_done high 1 cycle; then IDLE for 1 cycle, then RUN; all samples read 0.
6. rst pulsed 1 cycle mid-RUN and again mid-CLEAR (clr_cnt=100) -> next cycle state IDLE, phase=0, ftw_reg=0, sample=0, sample_valid=0, ram_we=0, clear_done never pulses.
